// File: rtl/writeback_unit.sv
// Writeback stage: merges the single-cycle ALU path and a 2-entry buffered load path onto the
// register file write port, and tracks outstanding destinations in a pending scoreboard.
module writeback_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [4:0]      load_rd,
  input  logic [XLEN-1:0] load_data,
  output logic            RegWrite,
  output logic [4:0]      write_address,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     pending
);

  logic [1:0][4:0]      fifo_rd_q;
  logic [1:0][XLEN-1:0] fifo_data_q;
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           count_q;
  logic [1:0]           count_d;
  logic [2:0]           starve_q;
  logic [2:0]           starve_d;

  logic                 alu_fire;
  logic                 push;
  logic                 pop;
  logic                 commit;
  logic [4:0]           sel_rd;
  logic [XLEN-1:0]      sel_data;
  logic [31:0]          set_vec;
  logic [31:0]          clr_vec;
  logic [31:0]          pending_d;

  // Readies depend on registered state only, so no input-to-output path exists.
  assign load_ready = (count_q != 2'd2);
  assign alu_ready  = (starve_q != 3'(STARVE_LIMIT));

  assign alu_fire = alu_valid & alu_ready;
  assign push     = load_valid & load_ready;
  // A push is only visible to selection from the following cycle.
  assign pop      = ~alu_fire & (count_q != 2'd0);
  assign commit   = alu_fire | pop;

  always_comb begin
    sel_rd   = fifo_rd_q[rd_ptr_q];
    sel_data = fifo_data_q[rd_ptr_q];
    if (alu_fire) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || (count_q == 2'd0)) begin
      starve_d = 3'd0;
    end else if (alu_fire) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // Set is applied after clear so a newly issued producer stays outstanding.
  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (issue_valid) begin
      set_vec[issue_rd] = 1'b1;
    end
    if (commit) begin
      clr_vec[sel_rd] = 1'b1;
    end
    pending_d    = (pending & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_rd_q   <= '0;
      fifo_data_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      starve_q    <= 3'd0;
    end else begin
      if (push) begin
        fifo_rd_q[wr_ptr_q]   <= load_rd;
        fifo_data_q[wr_ptr_q] <= load_data;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite      <= 1'b0;
      write_address <= 5'd0;
      write_data    <= '0;
      pending       <= 32'd0;
    end else begin
      RegWrite <= commit && (sel_rd != 5'd0);
      if (commit) begin
        write_address <= sel_rd;
        write_data    <= sel_data;
      end
      pending <= pending_d;
    end
  end

endmodule
